// File: rtl/pid_pkg.sv
// Shared widths and helpers for the heading PID drive mixer.
package pid_pkg;

  localparam int ERR_W   = 10;
  localparam int P_W     = 14;
  localparam int I_W     = 12;
  localparam int D_W     = 13;
  localparam int SPD_W   = 12;
  localparam int FRWRD_W = 11;
  localparam int PID_W   = 15;

  // Clamp a 13-bit signed value into the 12-bit signed speed range.
  function automatic logic [SPD_W-1:0] sat_spd(input logic [SPD_W:0] x);
    if (x[SPD_W] != x[SPD_W-1]) begin
      return x[SPD_W] ? {1'b1, {(SPD_W-1){1'b0}}} : {1'b0, {(SPD_W-1){1'b1}}};
    end
    return x[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/frwrd_ramp.sv
// Forward-speed ramp: climbs while moving, falls twice as fast when stopped, never wraps.
module frwrd_ramp
  import pid_pkg::*;
#(
  parameter bit                   FAST_SIM  = 1'b0,
  parameter int unsigned          RAMP_INC  = 4,
  parameter logic [FRWRD_W-1:0]   MAX_FRWRD = 11'h2A0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hdng_vld,
  input  logic               moving,
  output logic [FRWRD_W-1:0] frwrd
);

  localparam int unsigned IncInt = FAST_SIM ? 32 : RAMP_INC;
  localparam logic [FRWRD_W:0] Inc = (FRWRD_W + 1)'(IncInt);
  localparam logic [FRWRD_W:0] Dec = (FRWRD_W + 1)'(2 * IncInt);

  logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
  logic [FRWRD_W:0]   up_sum, dn_sum;

  // One extra bit so the clamp decisions see past the 11-bit range.
  assign up_sum = {1'b0, frwrd_q} + Inc;
  assign dn_sum = {1'b0, frwrd_q} - Dec;

  always_comb begin
    frwrd_d = frwrd_q;
    if (hdng_vld) begin
      if (moving) begin
        frwrd_d = (up_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : up_sum[FRWRD_W-1:0];
      end else begin
        frwrd_d = ({1'b0, frwrd_q} < Dec) ? '0 : dn_sum[FRWRD_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frwrd_q <= '0;
    else        frwrd_q <= frwrd_d;
  end

  assign frwrd = frwrd_q;

endmodule

// File: rtl/pid_drive_mix.sv
// Sums the heading PID terms, mixes them with the forward ramp into saturated left/right
// speed commands, and flags when the heading error is inside the at-heading window.
module pid_drive_mix
  import pid_pkg::*;
#(
  parameter bit                 FAST_SIM       = 1'b0,
  parameter int unsigned        RAMP_INC       = 4,
  parameter logic [FRWRD_W-1:0] MAX_FRWRD      = 11'h2A0,
  parameter int unsigned        AT_HDNG_THRESH = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             moving,
  input  logic             hdng_vld,
  input  logic [ERR_W-1:0] err_sat,
  input  logic [P_W-1:0]   P_term,
  input  logic [I_W-1:0]   I_term,
  input  logic [D_W-1:0]   D_term,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             at_hdng
);

  localparam logic [ERR_W:0] Thresh = (ERR_W + 1)'(AT_HDNG_THRESH);

  logic [FRWRD_W-1:0] frwrd;
  logic [PID_W-1:0]   pid_sum, pid_q;
  logic [SPD_W-1:0]   pid_div;
  logic [SPD_W:0]     lft_sum, rght_sum;
  logic [ERR_W:0]     err_ext, err_abs;
  logic               unused_pid_lsbs;

  frwrd_ramp #(
    .FAST_SIM  (FAST_SIM),
    .RAMP_INC  (RAMP_INC),
    .MAX_FRWRD (MAX_FRWRD)
  ) u_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .hdng_vld (hdng_vld),
    .moving   (moving),
    .frwrd    (frwrd)
  );

  assign pid_sum = {P_term[P_W-1], P_term}
                 + {{(PID_W - I_W){I_term[I_W-1]}}, I_term}
                 + {{(PID_W - D_W){D_term[D_W-1]}}, D_term};

  // Arithmetic >>> 3 of the 15-bit sum is exactly its upper 12 bits.
  assign pid_div         = pid_q[PID_W-1:3];
  assign unused_pid_lsbs = ^pid_q[2:0];

  assign lft_sum  = {2'b00, frwrd} + {pid_div[SPD_W-1], pid_div};
  assign rght_sum = {2'b00, frwrd} - {pid_div[SPD_W-1], pid_div};

  // Widen before negating so -512 becomes +512 rather than wrapping.
  assign err_ext = {err_sat[ERR_W-1], err_sat};
  assign err_abs = err_sat[ERR_W-1] ? (~err_ext + 1'b1) : err_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_q    <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      at_hdng  <= 1'b0;
    end else begin
      pid_q    <= pid_sum;
      lft_spd  <= moving ? sat_spd(lft_sum) : '0;
      rght_spd <= moving ? sat_spd(rght_sum) : '0;
      at_hdng  <= (err_abs < Thresh);
    end
  end

endmodule
